mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
Transmit-side front end for the 16-pair dot-product MAC array (4 PEs x 4 Booth multipliers, 20-bit result). Accepts a byte stream of 32 signed operands over a valid/ready handshake and buffers one full frame. It then drives the MAC's 32 parallel operand inputs and its reset_mul/reset_add controls, waits out the MAC pipeline, and returns the 20-bit dot product over a valid/ready result handshake.

Parameters:
N_PAIRS, 16, operand pairs per frame (frame = 2*N_PAIRS bytes)
DW, 8, operand width (signed)
RW, 20, MAC result width (signed)
MAC_LAT, 2, MAC register stages from operand sample to result (mul input regs + adder output reg)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
s_valid  input  1  operand byte valid
s_ready  output  1  feeder accepts operand byte
s_data  input  DW  signed operand byte
s_last  input  1  marks final byte of frame
mac_opnd  output  2*N_PAIRS*DW  flat operand bus; byte k drives the k-th MAC operand input in MAC port order (a,b,c,d,e,f,g,h,a1,...,h3)
mac_reset_mul  output  1  to MAC reset_mul
mac_reset_add  output  1  to MAC reset_add
mac_result  input  RW  MAC dot-product output
m_valid  output  1  result valid
m_ready  input  1  downstream accepts result
m_data  output  RW  signed dot product
err_frame  output  1  one-cycle framing-error pulse

Behaviour:
- Reset, synchronous and active-high: state=LOAD, byte count=0, operand buffer=0, m_data=0, m_valid=0, err_frame=0. While reset is high, s_ready=0 and mac_reset_mul=mac_reset_add=1.
- States are LOAD, ISSUE, OUT.
- LOAD:
  - s_ready=1. A byte transfers on s_valid&&s_ready and is written to buffer slot count.
  - count increments; wraps to 0 at 2*N_PAIRS-1.
  - When the byte at count=2*N_PAIRS-1 transfers, go to ISSUE.
  - mac_reset_mul and mac_reset_add are held at 1 to keep the MAC pipeline cleared.
- Framing:
  - s_last on a byte with count<2*N_PAIRS-1 aborts the frame: count->0, err_frame=1 for one cycle, stay in LOAD. Buffer contents are don't-care until overwritten.
  - Missing s_last on byte 2*N_PAIRS-1 pulses err_frame, but the frame is still issued.
- ISSUE:
  - s_ready=0. mac_reset_mul=mac_reset_add=0, decoded from state only (no input-to-output combinational path).
  - A wait counter runs MAC_LAT+1 cycles.
  - At the clock edge ending the last ISSUE cycle, m_data<=mac_result and state goes to OUT.
  - Latency: m_valid rises the cycle after the (MAC_LAT+1)th rising edge following the last-byte handshake (3 edges at default).
- OUT:
  - m_valid=1 and m_data is held stable until m_valid&&m_ready.
  - On that transfer: m_valid->0, count->0, state->LOAD.
  - mac_reset_* return to 1. s_ready stays 0 during OUT, so no overlap between frames.
- mac_opnd always reflects the buffer registers and is held stable through ISSUE.
- m_data is passed through unchanged as signed RW bits; no saturation.
- Reset asserted in any state restores reset values on the next edge. An interrupted frame is never emitted, and the next frame starts at count 0.

Test Plan:
1. Frame of 16 pairs, a=1 and b=1, s_valid continuous, m_ready=1 -> m_data=16. m_valid rises exactly 3 edges after the last-byte handshake and is high for 1 cycle.
2. All pairs a=-128, b=127 -> m_data=-260096 (0xC0800 in 20 bits). Pairs k=0..15 with a=k, b=-3 -> m_data=-360.
3. Result ready, m_ready held low 5 cycles -> m_valid and m_data stable, s_ready=0, mac_opnd unchanged. Raise m_ready -> m_valid drops next cycle and s_ready=1.
4. s_last on byte 10 -> err_frame pulses once, count resets. A following full frame of a=2, b=3 gives m_data=96.
5. Reset asserted during the second ISSUE cycle -> next cycle m_valid=0, s_ready=1 (reset released), mac_reset_*=1. No result for that frame. The next frame gives the correct sum.
6. s_valid gapped (1 cycle on, 2 off) over a full frame, with no s_last on byte 31 -> only handshaked bytes are counted, err_frame pulses once, and the result still matches the reference dot product.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers one frame of signed operand bytes, presents the
// frame to the dot-product MAC array, waits out the MAC pipeline and returns
// the MAC result over a valid/ready handshake.
module mac_operand_feeder #(
    parameter int N_PAIRS = 16,
    parameter int DW      = 8,
    parameter int RW      = 20,
    parameter int MAC_LAT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    input  logic                      s_last,
    output logic [2*N_PAIRS*DW-1:0]   mac_opnd,
    output logic                      mac_reset_mul,
    output logic                      mac_reset_add,
    input  logic [RW-1:0]             mac_result,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [RW-1:0]             m_data,
    output logic                      err_frame
);

    localparam int NB = 2 * N_PAIRS;
    localparam int CW = $clog2(NB);
    // One extra code so the wait counter can hold MAC_LAT even when MAC_LAT=0
    localparam int WW = $clog2(MAC_LAT + 2);
    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
    localparam logic [WW-1:0] WAIT_END = WW'(MAC_LAT);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WW-1:0]          wait_q, wait_d;
    logic [NB-1:0][DW-1:0]  buf_q, buf_d;
    logic [RW-1:0]          m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   err_q, err_d;

    // Handshake and MAC control are decoded from state; reset forces the
    // idle/cleared view immediately so the MAC never sees a half frame.
    assign s_ready       = (state_q == LOAD) && !reset;
    assign mac_reset_mul = (state_q != ISSUE) || reset;
    assign mac_reset_add = (state_q != ISSUE) || reset;
    assign mac_opnd      = buf_q;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign err_frame     = err_q;

    // Next-state: load bytes, hold operands for the MAC pipeline, present result
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        buf_d     = buf_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        err_d     = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_valid && s_ready) begin
                    buf_d[cnt_q] = s_data;
                    if (cnt_q == LAST_IDX) begin
                        // Full frame: issue it even if s_last was missing
                        cnt_d   = '0;
                        wait_d  = '0;
                        err_d   = !s_last;
                        state_d = ISSUE;
                    end else if (s_last) begin
                        // Short frame: drop it and restart at slot 0
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (wait_q == WAIT_END) begin
                    m_data_d  = mac_result;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            wait_q    <= '0;
            buf_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            buf_q     <= buf_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: a behavioural two-stage MAC array model sits
// behind the DUT; every result is compared with a plain-arithmetic dot product.
module tb_mac_operand_feeder;

    localparam int N_PAIRS = 16;
    localparam int DW      = 8;
    localparam int RW      = 20;
    localparam int MAC_LAT = 2;
    localparam int NB      = 2 * N_PAIRS;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 s_valid, s_ready, s_last;
    logic [DW-1:0]        s_data;
    logic [NB*DW-1:0]     mac_opnd;
    logic                 mac_reset_mul, mac_reset_add;
    logic [RW-1:0]        mac_result;
    logic                 m_valid, m_ready;
    logic [RW-1:0]        m_data;
    logic                 err_frame;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    logic [DW-1:0] frame_b [NB];

    always #5 clk = ~clk;

    mac_operand_feeder #(.N_PAIRS(N_PAIRS), .DW(DW), .RW(RW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mac_opnd(mac_opnd), .mac_reset_mul(mac_reset_mul), .mac_reset_add(mac_reset_add),
        .mac_result(mac_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_frame(err_frame)
    );

    // MAC array model: operand input registers, then a summing output register
    function automatic logic [RW-1:0] mac_sum(input logic [NB*DW-1:0] v);
        int s = 0;
        for (int k = 0; k < N_PAIRS; k++)
            s += int'($signed(v[2*k*DW +: DW])) * int'($signed(v[(2*k+1)*DW +: DW]));
        return s[RW-1:0];
    endfunction

    logic [NB*DW-1:0] mac_op_r;
    logic [RW-1:0]    mac_acc;
    always @(posedge clk) begin
        mac_op_r <= mac_reset_mul ? '0 : mac_opnd;
        mac_acc  <= mac_reset_add ? '0 : mac_sum(mac_op_r);
    end
    assign mac_result = mac_acc;

    // Count framing-error pulses
    always @(negedge clk) if (err_frame === 1'b1) err_seen++;

    // Reference dot product of the current frame, truncated to RW bits
    function automatic logic [RW-1:0] ref_dot();
        int s = 0;
        for (int k = 0; k < N_PAIRS; k++) begin
            int a = $signed(frame_b[2*k]);
            int b = $signed(frame_b[2*k+1]);
            s += a * b;
        end
        return s[RW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Send bytes 0..n-1 of frame_b; s_last on index last_at; gap idle cycles after each
    task automatic send_frame(input int n, input int gap, input int last_at);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = frame_b[i];
            s_last  = (i == last_at);
            #1;
            chk("s_ready_load", s_ready, 1'b1);
            @(posedge clk); #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (m_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("res_arrives", m_valid, 1'b1);
    endtask

    // Full frame: send, wait for result, optionally stall m_ready, then drain
    task automatic run_frame(input int gap, input int hold, input bit with_last, output int lat);
        int e0;
        logic [RW-1:0]    d0;
        logic [NB*DW-1:0] op0;
        e0 = err_seen;
        m_ready = (hold == 0);
        send_frame(NB, gap, with_last ? NB - 1 : -1);
        if (gap == 0) chk("issue_mac_rst", {mac_reset_mul, mac_reset_add}, 2'b00);
        wait_res(lat);
        chk("m_data", m_data, ref_dot());
        d0  = m_data;
        op0 = mac_opnd;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, d0);
            chk("hold_sready", s_ready, 1'b0);
            chk("hold_opnd", mac_opnd, op0);
        end
        m_ready = 1'b1;
        tick();
        chk("drain_valid", m_valid, 1'b0);
        chk("drain_sready", s_ready, 1'b1);
        chk("drain_mac_rst", {mac_reset_mul, mac_reset_add}, 2'b11);
        chk("err_count", err_seen - e0, with_last ? 0 : 1);
    endtask

    initial begin
        int lat, e0;
        bit seen;
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) tick();
        chk("rst_sready", s_ready, 1'b0);
        chk("rst_mac_rst", {mac_reset_mul, mac_reset_add}, 2'b11);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 0);
        chk("rst_err", err_frame, 1'b0);
        chk("rst_opnd", mac_opnd, 0);
        reset = 1'b0;
        #1;
        chk("rel_sready", s_ready, 1'b1);

        // 1: all ones, latency and single-cycle valid
        foreach (frame_b[i]) frame_b[i] = 8'd1;
        run_frame(0, 0, 1'b1, lat);
        chk("ones_latency", lat, MAC_LAT + 1);

        // 2: extreme operands and a signed ramp
        for (int k = 0; k < N_PAIRS; k++) begin frame_b[2*k] = 8'h80; frame_b[2*k+1] = 8'h7f; end
        run_frame(0, 0, 1'b1, lat);
        chk("extreme_val", m_data === 20'hC0800 || m_valid === 1'b0, 1'b1);
        for (int k = 0; k < N_PAIRS; k++) begin frame_b[2*k] = 8'(k); frame_b[2*k+1] = 8'hfd; end
        run_frame(0, 0, 1'b1, lat);

        // 3: result stall with m_ready low for 5 cycles
        foreach (frame_b[i]) frame_b[i] = 8'($urandom);
        run_frame(0, 5, 1'b1, lat);

        // 4: early s_last aborts, following frame is clean
        foreach (frame_b[i]) frame_b[i] = 8'($urandom);
        e0 = err_seen;
        m_ready = 1'b1;
        send_frame(11, 0, 10);
        tick();
        chk("abort_err", err_seen - e0, 1);
        chk("abort_no_res", m_valid, 1'b0);
        for (int k = 0; k < N_PAIRS; k++) begin frame_b[2*k] = 8'd2; frame_b[2*k+1] = 8'd3; end
        run_frame(0, 0, 1'b1, lat);

        // 5: reset during the second ISSUE cycle drops the frame
        foreach (frame_b[i]) frame_b[i] = 8'($urandom);
        send_frame(NB, 0, NB - 1);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_mac_rst", {mac_reset_mul, mac_reset_add}, 2'b11);
        chk("mid_rst_sready", s_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_valid", m_valid, 1'b0);
        chk("post_rst_sready", s_ready, 1'b1);
        chk("post_rst_mac_rst", {mac_reset_mul, mac_reset_add}, 2'b11);
        chk("post_rst_opnd", mac_opnd, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); if (m_valid === 1'b1) seen = 1'b1; end
        chk("dropped_frame", seen, 1'b0);
        foreach (frame_b[i]) frame_b[i] = 8'($urandom);
        run_frame(0, 0, 1'b1, lat);

        // 6: gapped input, missing s_last
        foreach (frame_b[i]) frame_b[i] = 8'($urandom);
        run_frame(2, 0, 1'b0, lat);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            foreach (frame_b[i]) frame_b[i] = 8'($urandom);
            run_frame($urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 3) != 0), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
